mac_requant_pack: RTL and testbench

Downstream stage of the MAC unit: accepts signed 16-bit accumulator results over a valid/ready stream and adds a bias. It then applies a rounding arithmetic right shift, optional ReLU, and saturation to int8. Four int8 results are packed into one 32-bit word for the activation buffer write port. A two-register pipeline sustains one element per cycle when the consumer is ready.

---
 rtl/mac_requant_pack.sv | 185 ++++++++++++++++++
 tb/tb_mac_requant_pack.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant_pack.sv
// -----------------------------------------------------------------------------
// mac_requant_pack
//
// Takes signed 16-bit MAC accumulator results over a valid/ready stream. For
// each element it adds a bias, does a round-half-up arithmetic right shift,
// applies an optional ReLU and saturates to int8. Four int8 results are then
// packed into one 32-bit word for the activation buffer write port.
//
// The pipeline has two register stages:
//   S1     - one requantised byte plus its last flag
//   packer - up to three pending bytes plus the output word register
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_data               signed accumulator value
//   in_last               marks the final element of a vector
//   bias, shift, relu_en  per-element requantisation controls
//   out_valid/out_ready   output handshake
//   out_data              packed bytes, element 0 in [7:0]
//   out_keep              byte-valid mask
//   out_last              word holds the vector's final element
// -----------------------------------------------------------------------------
module mac_requant_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic [15:0] bias,
    input  logic [3:0]  shift,
    input  logic        relu_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last
);

    localparam int PACK = 4;

    // ---------------------------------------------------------------- state
    logic              s1_valid_q, s1_valid_d;
    logic [7:0]        s1_byte_q,  s1_byte_d;
    logic              s1_last_q,  s1_last_d;
    logic [23:0]       bytes_q,    bytes_d;
    logic [1:0]        count_q,    count_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q,  out_data_d;
    logic [PACK-1:0]   out_keep_q,  out_keep_d;
    logic              out_last_q,  out_last_d;

    // ------------------------------------------------------- requantisation
    // The 18-bit width holds the 17-bit sum plus the rounding constant
    // without overflow: 65534 + 16384 < 2^17.
    logic signed [17:0] sum_ext;
    logic signed [17:0] rounded;
    logic signed [17:0] relu_val;
    logic [7:0]         sat_byte;

    always_comb begin
        sum_ext = {{2{in_data[15]}}, in_data} + {{2{bias[15]}}, bias};
        if (shift == 4'd0) begin
            rounded = sum_ext;
        end else begin
            rounded = (sum_ext + (18'sd1 <<< (shift - 4'd1))) >>> shift;
        end

        relu_val = (relu_en && rounded[17]) ? 18'sd0 : rounded;

        if (relu_val > 18'sd127) begin
            sat_byte = 8'h7F;
        end else if (relu_val < -18'sd128) begin
            sat_byte = 8'h80;
        end else begin
            sat_byte = relu_val[7:0];
        end
    end

    // ------------------------------------------------------ handshake/pack
    logic s1_completes;
    logic s1_advance;
    logic accept;

    // NOTE: every signal driven here gets a value before any branch; otherwise
    // an unassigned path would infer a latch.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_byte_d   = s1_byte_q;
        s1_last_d   = s1_last_q;
        bytes_d     = bytes_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        // A completing advance needs the output register to be free, or to be
        // freed this cycle. A non-completing advance never waits.
        s1_completes = s1_valid_q && ((count_q == 2'(PACK - 1)) || s1_last_q);
        s1_advance   = s1_valid_q && !(s1_completes && out_valid_q && !out_ready);
        in_ready     = !s1_valid_q || s1_advance;
        accept       = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_advance) begin
            if (s1_completes) begin
                // Bytes above the current count may hold stale data from an
                // earlier word, so they are zeroed explicitly here.
                case (count_q)
                    2'd0: begin
                        out_data_d = {24'h0, s1_byte_q};
                        out_keep_d = 4'b0001;
                    end
                    2'd1: begin
                        out_data_d = {16'h0, s1_byte_q, bytes_q[7:0]};
                        out_keep_d = 4'b0011;
                    end
                    2'd2: begin
                        out_data_d = {8'h0, s1_byte_q, bytes_q[15:0]};
                        out_keep_d = 4'b0111;
                    end
                    default: begin
                        out_data_d = {s1_byte_q, bytes_q};
                        out_keep_d = 4'b1111;
                    end
                endcase
                out_last_d  = s1_last_q;
                out_valid_d = 1'b1;
                count_d     = 2'd0;
            end else begin
                case (count_q)
                    2'd0:    bytes_d[7:0]   = s1_byte_q;
                    2'd1:    bytes_d[15:8]  = s1_byte_q;
                    default: bytes_d[23:16] = s1_byte_q;
                endcase
                count_d = count_q + 2'd1;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_byte_d  = sat_byte;
            s1_last_d  = in_last;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_byte_q   <= 8'h0;
            s1_last_q   <= 1'b0;
            bytes_q     <= 24'h0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_byte_q   <= s1_byte_d;
            s1_last_q   <= s1_last_d;
            bytes_q     <= bytes_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mac_requant_pack.sv
// -----------------------------------------------------------------------------
// tb_mac_requant_pack
//
// Directed bench for mac_requant_pack. The main process drives inputs at the
// falling edge. A monitor records every word popped by the consumer and
// checks that a stalled word holds stable. Expected words are hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_mac_requant_pack;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [15:0] bias;
    logic [3:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    // Each entry is {last, keep, data}.
    logic [36:0] words_q[$];

    mac_requant_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge. Inputs are stable
    // from then until the next rising edge.
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev;
    logic [3:0]  keep_prev;
    logic        last_prev;

    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_data", out_data, data_prev);
                check("hold_keep", {28'h0, out_keep}, {28'h0, keep_prev});
                check("hold_last", {31'h0, out_last}, {31'h0, last_prev});
            end
            if (out_valid && out_ready) begin
                words_q.push_back({out_last, out_keep, out_data});
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            keep_prev = out_keep;
            last_prev = out_last;
        end
    end

    // Presents one element and returns just after the edge that accepts it.
    // in_valid stays high, so the caller either sends again or calls idle().
    task automatic send(input logic [15:0] d, input logic [15:0] b, input logic [3:0] sh,
                        input logic relu, input logic last);
        int n;
        @(negedge clk);
        in_data  = d;
        bias     = b;
        shift    = sh;
        relu_en  = relu;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", {31'h0, in_ready}, 32'h1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] data,
                               input logic [3:0] keep, input logic last);
        int n;
        logic [36:0] w;
        n = 0;
        while (words_q.size() == 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (words_q.size() == 0) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            w = words_q.pop_front();
            check({tag, "_data"}, w[31:0], data);
            check({tag, "_keep"}, {28'h0, w[35:32]}, {28'h0, keep});
            check({tag, "_last"}, {31'h0, w[36]}, {31'h0, last});
        end
    endtask

    // One-element vector: the requantised byte lands alone in byte 0.
    task automatic single(input string tag, input logic [15:0] d, input logic [15:0] b,
                          input logic [3:0] sh, input logic relu, input logic [7:0] exp_byte);
        send(d, b, sh, relu, 1'b1);
        idle();
        expect_word(tag, {24'h0, exp_byte}, 4'h1, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        bias      = 16'h0;
        shift     = 4'h0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_keep", {28'h0, out_keep}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic full word, including the latency of the completing element.
        send(16'd70, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd20, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd50, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd1,  16'd0, 4'd0, 1'b0, 1'b1);
        idle();
        #1;
        check("lat_in_s1", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("lat_out", {31'h0, out_valid}, 32'h1);
        expect_word("basic", 32'h01321446, 4'hF, 1'b1);

        // Saturation and ReLU.
        single("sat_pos",  16'd300,  16'd0,     4'd0, 1'b0, 8'h7F);
        single("sat_neg",  -16'sd300, 16'd0,    4'd0, 1'b0, 8'h80);
        single("relu_neg", -16'sd300, 16'd0,    4'd0, 1'b1, 8'h00);
        single("no_wrap",  16'd32767, 16'd32767, 4'd0, 1'b0, 8'h7F);

        // Rounding.
        single("rnd_p7",   16'd7,     16'd0, 4'd1,  1'b0, 8'h04);
        single("rnd_m7",   -16'sd7,   16'd0, 4'd1,  1'b0, 8'hFD);
        single("rnd_p6",   16'd6,     16'd0, 4'd1,  1'b0, 8'h03);
        single("rnd_s15",  16'd16384, 16'd0, 4'd15, 1'b0, 8'h01);

        // Partial word.
        send(16'd1, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd2, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd3, 16'd0, 4'd0, 1'b0, 1'b1);
        idle();
        expect_word("partial", 32'h00030201, 4'h7, 1'b1);

        // Backpressure: 12 elements, consumer stalled for 10 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++) begin
                    send(16'(i), 16'd0, 4'd0, 1'b0, (i == 12));
                end
                idle();
            end
            begin
                repeat (10) @(negedge clk);
                check("bp_in_ready", {31'h0, in_ready}, 32'h0);
                check("bp_out_valid", {31'h0, out_valid}, 32'h1);
                check("bp_out_data", out_data, 32'h04030201);
                out_ready = 1'b1;
            end
        join
        expect_word("bp_w0", 32'h04030201, 4'hF, 1'b0);
        expect_word("bp_w1", 32'h08070605, 4'hF, 1'b0);
        expect_word("bp_w2", 32'h0C0B0A09, 4'hF, 1'b1);
        repeat (5) @(negedge clk);
        #3;
        check("bp_no_trailing", 32'(words_q.size()), 32'h0);

        // Reset in the middle of a vector.
        send(16'd5, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd6, 16'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;
        send(16'd9, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd8, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd7, 16'd0, 4'd0, 1'b0, 1'b0);
        send(16'd6, 16'd0, 4'd0, 1'b0, 1'b1);
        idle();
        expect_word("post_rst", 32'h06070809, 4'hF, 1'b1);
        repeat (5) @(negedge clk);
        #3;
        check("post_rst_no_extra", 32'(words_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
